// File: rtl/eeprom_i2c_master.sv
// rtl/eeprom_i2c_master.sv - I2C master for a 2 Kbyte serial EEPROM: byte write and random read.
// Define EEPROM_ACK_CHK_EN to evaluate slave ACK slots and abort to STOP on NACK.
module eeprom_i2c_master #(
   parameter int QDIV = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rw,
   input  logic [10:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        scl,
   inout  wire         sda
);

   localparam int QW = $clog2(QDIV);
   localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CTRL_W, S_ACK1, S_ADDR, S_ACK2, S_WDATA, S_ACK3,
      S_RSTART, S_CTRL_R, S_ACK4, S_RDATA, S_MNACK, S_STOP, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]  quarter_q, quarter_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic        rw_q, rw_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ack_err_q, ack_err_d;
   logic        scl_q, scl_d;
   logic        sda_low_q, sda_low_d;
`ifdef EEPROM_ACK_CHK_EN
   logic        smp_q, smp_d;
`endif

   logic        sda_in;
   logic        q_last;
   logic        slot_end;
   logic        sample_pt;
   logic [7:0]  tx_byte;
   logic [2:0]  bit_idx;

   assign sda      = sda_low_q ? 1'b0 : 1'bz;
   assign sda_in   = sda;
   assign scl      = scl_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
`ifdef EEPROM_ACK_CHK_EN
   assign ack_err  = ack_err_q;
`else
   assign ack_err  = 1'b0;
`endif

   assign q_last    = (qcnt_q == QLAST);
   assign slot_end  = q_last && (quarter_q == 2'd3);
   assign sample_pt = q_last && (quarter_q == 2'd2);

   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      quarter_d = quarter_q;
      bitcnt_d  = bitcnt_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rx_d      = rx_q;
      rdata_d   = rdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
`ifdef EEPROM_ACK_CHK_EN
      smp_d     = smp_q;
`endif
      scl_d     = 1'b1;
      sda_low_d = 1'b0;
      tx_byte   = 8'h00;
      bit_idx   = 3'd0;

      if (state_q == S_IDLE || state_q == S_DONE) begin
         state_d = S_IDLE;
         if (start) begin
            rw_d      = rw;
            addr_d    = addr;
            wdata_d   = wdata;
            ack_err_d = 1'b0;
            busy_d    = 1'b1;
            qcnt_d    = '0;
            quarter_d = 2'd0;
            bitcnt_d  = 3'd0;
            state_d   = S_START;
         end
      end else begin
         if (q_last) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
         end else begin
            qcnt_d    = qcnt_q + QW'(1);
         end

         if (sample_pt) begin
`ifdef EEPROM_ACK_CHK_EN
            smp_d = sda_in;
`endif
            if (state_q == S_RDATA)
               rx_d = {rx_q[6:0], sda_in};
         end

         if (slot_end) begin
            case (state_q)
               S_START:  state_d = S_CTRL_W;
               S_CTRL_W: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_ACK1;
               end
               S_ACK1:   state_d = S_ADDR;
               S_ADDR: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_ACK2;
               end
               S_ACK2:   state_d = rw_q ? S_RSTART : S_WDATA;
               S_WDATA: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_ACK3;
               end
               S_ACK3:   state_d = S_STOP;
               S_RSTART: state_d = S_CTRL_R;
               S_CTRL_R: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = S_ACK4;
               end
               S_ACK4:   state_d = S_RDATA;
               S_RDATA: begin
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     state_d = S_MNACK;
                     rdata_d = rx_q;
                  end
               end
               S_MNACK:  state_d = S_STOP;
               S_STOP: begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
               default:  state_d = S_IDLE;
            endcase
`ifdef EEPROM_ACK_CHK_EN
            if ((state_q == S_ACK1 || state_q == S_ACK2 || state_q == S_ACK3 ||
                 state_q == S_ACK4) && smp_q) begin
               ack_err_d = 1'b1;
               state_d   = S_STOP;
            end
`endif
         end
      end

      case (state_d)
         S_CTRL_W: tx_byte = {4'b1010, addr_q[10:8], 1'b0};
         S_CTRL_R: tx_byte = {4'b1010, addr_q[10:8], 1'b1};
         S_ADDR:   tx_byte = addr_q[7:0];
         S_WDATA:  tx_byte = wdata_q;
         default:  tx_byte = 8'h00;
      endcase
      bit_idx = 3'd7 - bitcnt_d;

      // Outputs are computed for the position being entered so scl/sda come straight from flops.
      case (state_d)
         S_START, S_RSTART: begin
            // A repeated START holds SCL low in q0 so the slave can release its ACK first.
            scl_d     = (quarter_d != 2'd3) && !(state_d == S_RSTART && quarter_d == 2'd0);
            sda_low_d = quarter_d[1];
         end
         S_CTRL_W, S_ADDR, S_WDATA, S_CTRL_R: begin
            scl_d     = quarter_d[1];
            sda_low_d = !tx_byte[bit_idx];
         end
         S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RDATA, S_MNACK: begin
            scl_d     = quarter_d[1];
            sda_low_d = 1'b0;
         end
         S_STOP: begin
            scl_d     = (quarter_d != 2'd0);
            sda_low_d = (quarter_d != 2'd3);
         end
         default: begin
            scl_d     = 1'b1;
            sda_low_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         quarter_q <= 2'd0;
         bitcnt_q  <= 3'd0;
         rw_q      <= 1'b0;
         addr_q    <= 11'd0;
         wdata_q   <= 8'd0;
         rx_q      <= 8'd0;
         rdata_q   <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
`ifdef EEPROM_ACK_CHK_EN
         smp_q     <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         quarter_q <= quarter_d;
         bitcnt_q  <= bitcnt_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rx_q      <= rx_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sda_low_q <= sda_low_d;
`ifdef EEPROM_ACK_CHK_EN
         smp_q     <= smp_d;
`endif
      end
   end

endmodule

// File: doc/eeprom_i2c_master.md
Name: eeprom_i2c_master

Overview:
- I2C bus master that drives the 2 Kbyte serial EEPROM (11-bit address, control byte 1010_AAA_R/W) from a simple parallel command interface.
- Supports two transactions: byte write, and random read (dummy write, repeated START, read).
- Sits between system logic and the external scl/sda pins.
- Generates all bus timing from the system clock.

Parameters:
- QDIV, 250, clk cycles per quarter SCL period; SCL period = 4*QDIV clk. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  command strobe; accepted only when busy=0
- rw  input  1  1 = random read, 0 = byte write; sampled with start
- addr  input  11  EEPROM byte address; sampled with start
- wdata  input  8  write data; sampled with start
- rdata  output  8  read data; valid when done pulses after a read
- busy  output  1  transaction in progress
- done  output  1  one-clk pulse at transaction end
- ack_err  output  1  slave NACK seen in last transaction (see optional feature)
- scl  output  1  bus clock, push-pull
- sda  inout  1  open-drain: driven 0 or z, never 1; sampled as input

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: scl=1, sda=z, busy=0, done=0, ack_err=0, rdata=0. FSM goes to IDLE and quarter/bit counters go to 0.
- Reset mid-transaction aborts immediately with no STOP. The bench must tolerate the slave left mid-byte.
- Latching: start && !busy latches rw, addr and wdata. busy=1 from the next cycle. start while busy is ignored.
- Bit slot: 4 quarters of QDIV clk each.
  - Data bit: q0 SCL low and SDA updated; q1 SCL low; q2 SCL high; q3 SCL high.
  - SDA is sampled on the last clk of q2.
  - SDA changes only while SCL is low, except START and STOP.
- START slot: SDA released and SCL high for q0–q1; SDA low at q2; SCL low at end of q3.
- STOP slot: SDA low in q0–q1; SCL high from q1; SDA released at q3.
- Byte order: MSB first, 8 bits, then a 9th ACK slot.
  - Master releases SDA during slave ACK slots.
  - Master drives SDA low for its own ACK; releases SDA (NACK) after the final read byte.
- Control byte: {4'b1010, addr[10:8], dir}. Address byte: addr[7:0].
- FSM states: IDLE, START, CTRL_W, ACK1, ADDR, ACK2, then a branch on rw, then STOP, DONE.
  - Write branch: WDATA, ACK3.
  - Read branch: RSTART (repeated START, same timing as START), CTRL_R, ACK4, RDATA, MNACK.
- Slot counts:
  - Write = 29 slots: 1 + 9 + 9 + 9 + 1.
  - Read = 39 slots: 1 + 9 + 9 + 1 + 9 + 9 + 1.
- Latency: done pulses exactly 4*QDIV*slots clk after the start-accept cycle. busy falls in the same cycle as done.
- Read data: rdata updates only at the end of RDATA and holds until the next read completes.
- Bit counter: 3-bit, wraps 7->0 at the ACK transition.
- Quarter counter counts 0..QDIV-1.
- ack_err is cleared on start accept.

Optional Feature:
- Macro: EEPROM_ACK_CHK_EN.
- Defined:
  - Master samples SDA in each slave ACK slot (ACK1–ACK4).
  - SDA=1 sets ack_err=1, skips the remaining slots and goes directly to STOP, then DONE. done still pulses.
  - rdata is unchanged on an aborted read.
- Undefined:
  - ACK slots are clocked but not evaluated; the transaction always runs full length.
  - ack_err is tied to 0.

Test Plan:
- Byte write, QDIV=4, rw=0, addr=11'h123, wdata=8'h5A, with the EEPROM model on the bus.
  - Bus shows START, then bytes A2 / 23 / 5A each with ACK, then STOP.
  - done at 464 clk after start; model memory[0x123]=0x5A.
- Random read of 11'h123 after the write above.
  - Bus shows START A2, 23, Sr, A3, data 5A, NACK, STOP.
  - done at 624 clk after start; rdata=8'h5A; ack_err=0.
- Boundary address: write addr=11'h7FF, wdata=8'hC3, then read it back.
  - Control bytes AE and AF on the bus; address byte FF; rdata=8'hC3.
- Pulse start with different addr while busy=1 mid-write.
  - Ignored; bus sequence and memory identical to a single write.
- Assert rst for 1 clk during the ADDR byte.
  - Next cycle: scl=1, sda=z, busy=0, done never pulses; a following write completes normally.
- With EEPROM_ACK_CHK_EN and no slave (pull-up only), issue a write.
  - NACK in ACK1, then STOP; done at 4*QDIV*(1+9+1) = 176 clk after start; ack_err=1.
